// File: rtl/pipe_pkg.sv
// Shared pipeline widths and the execute/memory stage payload layout.
// DATA_W of stage_buf defaults to PAYLOAD_W derived here.
package pipe_pkg;

  localparam int XLEN  = 32;
  localparam int RSD_W = 5;
  localparam int OP_W  = 3;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [RSD_W-1:0] rsd;
    logic [XLEN-1:0]  memory_data;
    logic [XLEN-1:0]  alu_result;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

endpackage

// File: rtl/stage_buf_if.sv
// Valid/ready handshake bundle for stage_buf: upstream push side and downstream pop side.
// slave = the buffer's view, master = the surrounding pipeline's view.
interface stage_buf_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/stage_buf_ctrl.sv
// Pointer, occupancy and push/pop/flush arbitration for stage_buf.
// Ready/valid come straight from the occupancy register, never from the opposite handshake.
module stage_buf_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             push_o,
  output logic             pop_o,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign in_ready_o  = (count_q < CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);

  // A flushing or resetting cycle moves no data in either direction.
  assign push_o = in_valid_i && in_ready_o && !flush_i && !rst_i;
  assign pop_o  = out_valid_o && out_ready_i && !flush_i && !rst_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_o)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_o, pop_o})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/stage_buf.sv
// Pipeline stage FIFO buffer (DEPTH entries, power of two >= 2) with valid/ready on both sides.
// Optional backpressure counter stall_cnt_o when STAGE_BUF_STALL_CNT_EN is defined.
module stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W,
  parameter int DEPTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  stage_buf_if.slave                   bus,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef STAGE_BUF_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             push, pop, in_ready, out_valid;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_q [DEPTH];

  stage_buf_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (bus.in_valid_i),
    .out_ready_i (bus.out_ready_i),
    .push_o      (push),
    .pop_o       (pop),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count_o)
  );

  // Storage is data only: neither reset nor flush touches it.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= bus.in_data_i;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  // Gating by valid keeps the output at zero after reset without clearing storage.
  assign bus.out_data_o  = out_valid ? mem_q[rd_ptr] : '0;

`ifdef STAGE_BUF_STALL_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready_i) stall_cnt_d = sat_inc32(stall_cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_pop;
  assign unused_pop = pop;
`endif

endmodule

// File: tb/tb_stage_buf.sv
// Scoreboard bench for stage_buf: a DEPTH=2 and a DEPTH=4 instance, directed vectors.
// Stall-counter checks compile in only when STAGE_BUF_STALL_CNT_EN is defined.
module tb_stage_buf;
  import pipe_pkg::*;

  localparam int DW = PAYLOAD_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush2 = 1'b0;
  logic flush4 = 1'b0;
  logic [1:0] cnt2;
  logic [2:0] cnt4;
`ifdef STAGE_BUF_STALL_CNT_EN
  logic [31:0] stall2, stall4;
`endif

  always #5 clk = ~clk;

  stage_buf_if #(.DATA_W(DW)) b2 ();
  stage_buf_if #(.DATA_W(DW)) b4 ();

  stage_buf #(.DATA_W(DW), .DEPTH(2)) dut2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush2),
    .bus     (b2),
    .count_o (cnt2)
`ifdef STAGE_BUF_STALL_CNT_EN
    ,
    .stall_cnt_o (stall2)
`endif
  );

  stage_buf #(.DATA_W(DW), .DEPTH(4)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush4),
    .bus     (b4),
    .count_o (cnt4)
`ifdef STAGE_BUF_STALL_CNT_EN
    ,
    .stall_cnt_o (stall4)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q2[$];
  logic [DW-1:0] q4[$];
  logic [DW-1:0] v4 [10];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic mon2();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !flush2 && b2.out_valid_o && b2.out_ready_i) begin
        total++;
        if (q2.size() == 0) begin
          bad++;
          $display("FAIL mon2_unexpected got=%0h want=none", b2.out_data_o);
        end else begin
          e = q2.pop_front();
          if (b2.out_data_o !== e) begin
            bad++;
            $display("FAIL mon2_data got=%0h want=%0h", b2.out_data_o, e);
          end
        end
      end
    end
  endtask

  task automatic mon4();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !flush4 && b4.out_valid_o && b4.out_ready_i) begin
        total++;
        if (q4.size() == 0) begin
          bad++;
          $display("FAIL mon4_unexpected got=%0h want=none", b4.out_data_o);
        end else begin
          e = q4.pop_front();
          if (b4.out_data_o !== e) begin
            bad++;
            $display("FAIL mon4_data got=%0h want=%0h", b4.out_data_o, e);
          end
        end
      end
    end
  endtask

  task automatic push2(input logic [DW-1:0] d);
    b2.in_valid_i = 1'b1;
    b2.in_data_i  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b2.in_ready_o && !flush2 && !rst) begin
        q2.push_back(d);
        tick();
        b2.in_valid_i = 1'b0;
        return;
      end
      tick();
    end
    total++;
    bad++;
    $display("FAIL push2_timeout got=stalled want=accepted data=%0h", d);
    b2.in_valid_i = 1'b0;
  endtask

  task automatic push4(input logic [DW-1:0] d);
    b4.in_valid_i = 1'b1;
    b4.in_data_i  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b4.in_ready_o && !flush4 && !rst) begin
        q4.push_back(d);
        tick();
        b4.in_valid_i = 1'b0;
        return;
      end
      tick();
    end
    total++;
    bad++;
    $display("FAIL push4_timeout got=stalled want=accepted data=%0h", d);
    b4.in_valid_i = 1'b0;
  endtask

  initial begin
    v4[0] = 72'h10_0000_0001_0000_0001;
    v4[1] = 72'h21_0000_0002_0000_0002;
    v4[2] = 72'h32_0000_0003_0000_0003;
    v4[3] = 72'h43_0000_0004_0000_0004;
    v4[4] = 72'h54_0000_0005_0000_0005;
    v4[5] = 72'h65_0000_0006_0000_0006;
    v4[6] = 72'h76_0000_0007_0000_0007;
    v4[7] = 72'h87_0000_0008_0000_0008;
    v4[8] = 72'h98_0000_0009_0000_0009;
    v4[9] = 72'hA9_0000_000A_0000_000A;

    b2.in_valid_i = 1'b0; b2.in_data_i = '0; b2.out_ready_i = 1'b0;
    b4.in_valid_i = 1'b0; b4.in_data_i = '0; b4.out_ready_i = 1'b0;

    fork
      mon2();
      mon4();
      begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset, with an offer during reset that must be ignored
    rst = 1'b1;
    b2.in_valid_i = 1'b1;
    b2.in_data_i  = 72'hEE_DEAD_BEEF_DEAD_BEEF;
    repeat (3) tick();
    rst = 1'b0;
    b2.in_valid_i = 1'b0;
    samp();
    check("rst_cnt2",   DW'(cnt2), 0);
    check("rst_vld2",   DW'(b2.out_valid_o), 0);
    check("rst_data2",  b2.out_data_o, 0);
    check("rst_rdy2",   DW'(b2.in_ready_o), 1);
    check("rst_cnt4",   DW'(cnt4), 0);
    check("rst_vld4",   DW'(b4.out_valid_o), 0);

    // Single entry through an empty buffer
    tick();
    b2.out_ready_i = 1'b1;
    push2(72'h00_0000_0000_0000_00AA);
    samp();
    check("lat_vld",  DW'(b2.out_valid_o), 1);
    check("lat_data", b2.out_data_o, 72'h00_0000_0000_0000_00AA);
    check("lat_cnt",  DW'(cnt2), 1);
    tick();
    samp();
    check("lat_cnt_after", DW'(cnt2), 0);
    check("lat_vld_after", DW'(b2.out_valid_o), 0);

    // Fill DEPTH=2 under backpressure, third entry held upstream
    tick();
    b2.out_ready_i = 1'b0;
    fork
      begin
        push2(72'h11_AAAA_AAAA_0000_000A);
        push2(72'h22_BBBB_BBBB_0000_000B);
        push2(72'h33_CCCC_CCCC_0000_000C);
      end
    join_none
    tick();
    tick();
    samp();
    check("full_cnt",  DW'(cnt2), 2);
    check("full_rdy",  DW'(b2.in_ready_o), 0);
    check("full_vld",  DW'(b2.out_valid_o), 1);
    check("full_head", b2.out_data_o, 72'h11_AAAA_AAAA_0000_000A);
    tick();
    samp();
    check("hold_head", b2.out_data_o, 72'h11_AAAA_AAAA_0000_000A);
    check("hold_cnt",  DW'(cnt2), 2);

    // Full with pop: no push that cycle, ready next cycle
    tick();
    b2.out_ready_i = 1'b1;
    samp();
    check("fullpop_rdy", DW'(b2.in_ready_o), 0);
    tick();
    samp();
    check("fullpop_cnt", DW'(cnt2), 1);
    check("fullpop_rdy_next", DW'(b2.in_ready_o), 1);
    repeat (3) tick();
    samp();
    check("drain_cnt2", DW'(cnt2), 0);
    check("drain_q2", DW'(q2.size()), 0);

    // Flush with a same-cycle push: D never emerges
    tick();
    b2.out_ready_i = 1'b0;
    push2(72'h44_EEEE_EEEE_0000_000E);
    b2.in_valid_i = 1'b1;
    b2.in_data_i  = 72'h55_DDDD_DDDD_0000_000D;
    flush2 = 1'b1;
    samp();
    check("flush_pre_cnt", DW'(cnt2), 1);
    check("flush_pre_rdy", DW'(b2.in_ready_o), 1);
    tick();
    flush2 = 1'b0;
    b2.in_valid_i = 1'b0;
    q2.delete();
    samp();
    check("flush_cnt", DW'(cnt2), 0);
    check("flush_vld", DW'(b2.out_valid_o), 0);
    tick();
    b2.out_ready_i = 1'b1;
    repeat (3) tick();
    push2(72'h66_FFFF_FFFF_0000_000F);
    samp();
    check("postflush_data", b2.out_data_o, 72'h66_FFFF_FFFF_0000_000F);
    check("postflush_vld",  DW'(b2.out_valid_o), 1);
    tick();

    // Reset mid-stream discards the stored entry
    b2.out_ready_i = 1'b0;
    push2(72'h77_1234_5678_9ABC_DEF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q2.delete();
    samp();
    check("midrst_cnt",  DW'(cnt2), 0);
    check("midrst_vld",  DW'(b2.out_valid_o), 0);
    check("midrst_data", b2.out_data_o, 0);
    check("midrst_rdy",  DW'(b2.in_ready_o), 1);
    tick();
    b2.out_ready_i = 1'b1;
    repeat (2) tick();

    // DEPTH=4 interleaved traffic across pointer wrap
    b4.out_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) push4(v4[i]);
      end
    join_none
    for (int c = 0; c < 40; c++) begin
      samp();
      check("cnt4_max", DW'(cnt4 <= 3'd4), 1);
      if (c == 5) begin
        check("cnt4_full", DW'(cnt4), 4);
        check("rdy4_full", DW'(b4.in_ready_o), 0);
      end
      tick();
      b4.out_ready_i = (c >= 5) && (c % 2 == 0);
    end
    b4.out_ready_i = 1'b1;
    repeat (5) tick();
    samp();
    check("drain_q4",   DW'(q4.size()), 0);
    check("drain_cnt4", DW'(cnt4), 0);

`ifdef STAGE_BUF_STALL_CNT_EN
    // Backpressure counter: 5 stalled cycles, unaffected by flush, cleared by reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b2.out_ready_i = 1'b0;
    q2.delete();
    push2(72'h88_0000_0055_0000_0055);
    repeat (5) tick();
    flush2 = 1'b1;
    b2.out_ready_i = 1'b1;
    samp();
    check("stall_5", DW'(stall2), 5);
    tick();
    flush2 = 1'b0;
    b2.out_ready_i = 1'b0;
    q2.delete();
    samp();
    check("stall_after_flush", DW'(stall2), 5);
    check("stall_flush_cnt",   DW'(cnt2), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    samp();
    check("stall_rst", DW'(stall2), 0);
`endif

    samp();
    check("final_q2", DW'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_buf.md
STAGE_BUF -- requirements
Module: stage_buf

Interface
REQ-001 Parameter: DATA_W, 72, payload width in bits (default = alu_result 32 + memory_data 32 + rsd 5 + Op 3).
REQ-002 Parameter: DEPTH, 2, entry count; power of two, minimum 2.
REQ-003 Port: clk_i  input  1  single clock; all state updates on posedge.
REQ-004 Port: rst_i  input  1  synchronous, active-high reset.
REQ-005 Port: flush_i  input  1  synchronous discard of all stored entries.
REQ-006 Port: in_valid_i  input  1  upstream entry offered.
REQ-007 Port: in_ready_o  output  1  buffer can accept an entry this cycle.
REQ-008 Port: in_data_i  input  DATA_W  upstream payload.
REQ-009 Port: out_valid_o  output  1  head entry present.
REQ-010 Port: out_ready_i  input  1  downstream consumes head this cycle.
REQ-011 Port: out_data_o  output  DATA_W  head payload.
REQ-012 Port: count_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 Port: stall_cnt_o  output  32  backpressure cycle count; present only with STAGE_BUF_STALL_CNT_EN.

Function
REQ-014 Push = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i; both evaluated at posedge clk_i.
REQ-015 in_ready_o = (count_o < DEPTH); derived from state only, no combinational path from out_ready_i.
REQ-016 Full buffer with simultaneous pop: no push accepted that cycle; in_ready_o rises the following cycle.
REQ-017 out_valid_o = (count_o != 0); out_data_o = storage at read pointer; both driven from flops only.
REQ-018 Latency: entry pushed at edge N visible on out_data_o with out_valid_o=1 after edge N (one cycle, empty buffer).
REQ-019 Order strictly FIFO; write/read pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop with 0 < count_o < DEPTH: count_o unchanged, both pointers advance.
REQ-021 Push and pop simultaneously at count_o = 0: impossible (out_valid_o=0); push only.
REQ-022 While out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold stable.
REQ-023 flush_i=1: next cycle count_o=0, pointers=0, out_valid_o=0; same-cycle push and pop ignored.
REQ-024 Flush has priority over push/pop; reset has priority over flush.
REQ-025 Storage contents not cleared by flush; out_data_o is don't-care while out_valid_o=0.

Reset
REQ-026 rst_i=1 at posedge: count_o=0, pointers=0, out_valid_o=0, out_data_o=0, stall_cnt_o=0.
REQ-027 in_valid_i ignored on any cycle rst_i=1; in_ready_o=1 on the first cycle after reset release.
REQ-028 Reset mid-stream discards all entries; no partial pop reaches downstream.

Configuration
REQ-029 Macro STAGE_BUF_STALL_CNT_EN defined: stall_cnt_o increments each cycle with out_valid_o=1 && out_ready_i=0, saturates at 32'hFFFF_FFFF, cleared only by rst_i (not flush_i).
REQ-030 Macro undefined: stall_cnt_o port and counter absent; all other behaviour identical.

Structure
REQ-031 Package pipe_pkg holds default widths (XLEN=32, RSD_W=5, OP_W=3) and payload struct typedef {Op, rsd, memory_data, alu_result}; DATA_W default derived from it.
REQ-032 One sub-module stage_buf_ctrl: pointers, occupancy counter, push/pop/flush arbitration; storage array stays in stage_buf.

Verification
REQ-033 Reset release, push 0x...AA with out_ready_i=1 -> out_valid_o=1 next cycle, out_data_o=0x...AA, count_o=1, then 0 after pop.
REQ-034 DEPTH=2, out_ready_i=0, push A,B,C -> A,B accepted, in_ready_o=0 after B, C held upstream; release -> A then B then C in order.
REQ-035 Full, push+pop same cycle -> pop only, count_o 2->1, in_ready_o=1 next cycle.
REQ-036 count_o=1, push D with flush_i=1 -> count_o=0, out_valid_o=0 next cycle, D never emerges.
REQ-037 DEPTH=4, 10 pushes/pops interleaved -> pointer wrap verified, output order = input order, count_o never exceeds 4.
REQ-038 STAGE_BUF_STALL_CNT_EN, 5 backpressure cycles then flush -> stall_cnt_o=5 and unchanged by flush; rst_i -> 0.
